// File: rtl/switch_pkg.sv
// Shared types and constants for the bouncing-switch emulator.
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Galois taps for x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/switch_bounce_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every clock, seeded on reset.
module lfsr16
  import switch_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value <= SEED;
    else     value <= lfsr_next(value);
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Emulates a mechanical switch: bursts of randomly spaced toggles toward the
// requested level, then a long stable hold before signalling completion.
module switch_bounce_gen
  import switch_pkg::*;
#(
  parameter int          c_BOUNCE_COUNT  = 8,
  parameter int          c_MIN_INTERVAL  = 500,
  parameter int          c_SPAN_BITS     = 12,
  parameter int          c_SETTLE_CYCLES = 300_000,
  parameter logic [15:0] c_LFSR_SEED     = LFSR_SEED
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Start,
  input  logic i_Level,
  output logic o_Switch,
  output logic o_Busy,
  output logic o_Done
);

  localparam logic [8:0]  TOGGLES     = 9'(2 * c_BOUNCE_COUNT - 1);
  localparam logic [15:0] SPAN_MASK   = 16'((32'd1 << c_SPAN_BITS) - 32'd1);
  localparam logic [19:0] SETTLE_LOAD = 20'(c_SETTLE_CYCLES);
  localparam logic [19:0] MIN_LOAD    = 20'(c_MIN_INTERVAL);

  state_t      state, state_n;
  logic        target, target_n;
  logic        sw_n, busy_n, done_n;
  logic [19:0] ivl_cnt, ivl_n;
  logic [19:0] settle_cnt, settle_n;
  logic [8:0]  rem, rem_n;
  logic [15:0] lfsr;
  logic [19:0] interval;

  lfsr16 #(.SEED(c_LFSR_SEED)) u_lfsr (
    .clk   (i_Clk),
    .rst   (i_Rst),
    .value (lfsr)
  );

  assign interval = MIN_LOAD + 20'(lfsr & SPAN_MASK);

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state      <= IDLE;
      target     <= 1'b0;
      o_Switch   <= 1'b0;
      o_Busy     <= 1'b0;
      o_Done     <= 1'b0;
      ivl_cnt    <= '0;
      settle_cnt <= '0;
      rem        <= '0;
    end else begin
      state      <= state_n;
      target     <= target_n;
      o_Switch   <= sw_n;
      o_Busy     <= busy_n;
      o_Done     <= done_n;
      ivl_cnt    <= ivl_n;
      settle_cnt <= settle_n;
      rem        <= rem_n;
    end
  end

  always_comb begin
    state_n  = state;
    target_n = target;
    sw_n     = o_Switch;
    busy_n   = o_Busy;
    done_n   = 1'b0;
    ivl_n    = ivl_cnt;
    settle_n = settle_cnt;
    rem_n    = rem;
    unique case (state)
      IDLE: begin
        // The done cycle is still IDLE but must not accept a new start
        if (i_Start && !o_Done) begin
          target_n = i_Level;
          busy_n   = 1'b1;
          if (i_Level != o_Switch) begin
            sw_n = i_Level;
            if (TOGGLES == 9'd1) begin
              state_n  = SETTLE;
              settle_n = SETTLE_LOAD;
            end else begin
              state_n = BOUNCE;
              ivl_n   = interval;
              rem_n   = TOGGLES - 9'd1;
            end
          end else begin
            state_n  = SETTLE;
            settle_n = SETTLE_LOAD;
          end
        end
      end
      BOUNCE: begin
        if (ivl_cnt <= 20'd1) begin
          sw_n  = ~o_Switch;
          rem_n = rem - 9'd1;
          if (rem == 9'd1) begin
            sw_n     = target;
            state_n  = SETTLE;
            settle_n = SETTLE_LOAD;
            ivl_n    = '0;
          end else begin
            ivl_n = interval;
          end
        end else begin
          ivl_n = ivl_cnt - 20'd1;
        end
      end
      SETTLE: begin
        if (settle_cnt <= 20'd1) begin
          done_n   = 1'b1;
          busy_n   = 1'b0;
          state_n  = IDLE;
          settle_n = '0;
        end else begin
          settle_n = settle_cnt - 20'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Randomized bench for switch_bounce_gen: toggle timing derived from a
// reference LFSR sequence, plus reset-abort and done-cycle start cases.
module tb_switch_bounce_gen;

  localparam int          N    = 3;
  localparam int          MIN  = 4;
  localparam int          SET  = 10;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, level = 1'b0, start0 = 1'b0, level0 = 1'b0;
  logic sw, busy, done, sw0, busy0, done0;
  logic [15:0] m;

  int n_checks = 0;
  int n_fail   = 0;
  int gaps[16];
  int ngaps;
  int ref_gaps[16];

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .c_BOUNCE_COUNT(N), .c_MIN_INTERVAL(MIN), .c_SPAN_BITS(2),
    .c_SETTLE_CYCLES(SET), .c_LFSR_SEED(SEED)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Level(level),
    .o_Switch(sw), .o_Busy(busy), .o_Done(done)
  );

  switch_bounce_gen #(
    .c_BOUNCE_COUNT(N), .c_MIN_INTERVAL(MIN), .c_SPAN_BITS(0),
    .c_SETTLE_CYCLES(SET), .c_LFSR_SEED(SEED)
  ) dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(start0), .i_Level(level0),
    .o_Switch(sw0), .o_Busy(busy0), .o_Done(done0)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference pseudo-random sequence: value after each clock since reset
  always @(posedge clk or posedge rst) begin
    if (rst) m <= SEED;
    else     m <= lfsr_step(m);
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic l);
    if (sel) begin start0 = s; level0 = l; end
    else     begin start  = s; level  = l; end
  endtask

  function automatic logic [2:0] outs(input bit sel);
    return sel ? {sw0, busy0, done0} : {sw, busy, done};
  endfunction

  // One request on the chosen instance; abort_at>0 resets after that toggle
  task automatic txn(input bit sel, input logic lvl, input bit spam, input int abort_at);
    logic [2:0]  o;
    logic        prev_sw;
    logic [15:0] pm, mask;
    int exp_tog, ntog, exp_next, exp_done, last_t;
    mask = sel ? 16'h0 : 16'h3;
    @(negedge clk);
    o        = outs(sel);
    prev_sw  = o[2];
    exp_tog  = (lvl != prev_sw) ? 2 * N - 1 : 0;
    exp_next = 1;
    exp_done = (exp_tog == 0) ? 1 + SET : -1;
    ntog     = 0;
    ngaps    = 0;
    last_t   = 0;
    drive(sel, 1'b1, lvl);
    for (int c = 1; c <= 2000; c++) begin
      pm = m;
      @(negedge clk);
      o = outs(sel);
      drive(sel, spam, spam ? 1'($urandom) : 1'b0);
      if (o[2] != prev_sw) begin
        chk("toggle_time", c, exp_next);
        if (ntog > 0) begin gaps[ngaps] = c - last_t; ngaps++; end
        last_t   = c;
        ntog++;
        prev_sw  = o[2];
        exp_next = c + MIN + int'(pm & mask);
        if (ntog == exp_tog) exp_done = c + SET;
        if (ntog == abort_at) begin
          rst = 1'b1;
          #1;
          o = outs(sel);
          chk("abort_sw", int'(o[2]), 0);
          chk("abort_busy", int'(o[1]), 0);
          drive(sel, 1'b0, 1'b0);
          repeat (3) begin
            @(negedge clk);
            o = outs(sel);
            chk("abort_no_done", int'(o[0]), 0);
            chk("abort_busy_hold", int'(o[1]), 0);
          end
          rst = 1'b0;
          return;
        end
      end
      if (o[0]) begin
        chk("done_time", c, exp_done);
        chk("done_busy", int'(o[1]), 0);
        chk("final_level", int'(o[2]), int'(lvl));
        chk("toggle_count", ntog, exp_tog);
        drive(sel, 1'b1, ~lvl);
        @(negedge clk);
        o = outs(sel);
        drive(sel, 1'b0, 1'b0);
        chk("done_one_cycle", int'(o[0]), 0);
        chk("start_in_done_ignored", int'(o[1]), 0);
        chk("level_hold", int'(o[2]), int'(lvl));
        return;
      end
      chk("busy", int'(o[1]), 1);
    end
    chk("timeout_done", int'(outs(sel) & 3'b001), 1);
    drive(sel, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sw", int'(sw), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sw0", int'(sw0), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Full bounce 0 -> 1; keep its interval sequence as the reference
    txn(0, 1'b1, 0, 0);
    chk("gap_count", ngaps, 2 * N - 2);
    for (int i = 0; i < ngaps; i++) begin
      ref_gaps[i] = gaps[i];
      chk("gap_range", int'(gaps[i] >= MIN && gaps[i] <= MIN + 3), 1);
    end

    // Same level again: settle only
    txn(0, 1'b1, 0, 0);

    // Starts hammered during the bounce must not disturb it
    txn(0, 1'b0, 1, 0);

    // Reset between toggles 3 and 4, then repeat the first run exactly
    txn(0, 1'b1, 0, 3);
    repeat (3) @(negedge clk);
    txn(0, 1'b1, 0, 0);
    chk("rerun_gap_count", ngaps, 2 * N - 2);
    for (int i = 0; i < ngaps; i++) chk("rerun_same_gap", gaps[i], ref_gaps[i]);

    // Zero span: fixed intervals
    txn(1, 1'b1, 0, 0);
    for (int i = 0; i < ngaps; i++) chk("fixed_gap", gaps[i], MIN);

    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      txn(1'($urandom), 1'($urandom), 1'($urandom), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_bounce_gen.md
SWITCH_BOUNCE_GEN -- requirements
Module: switch_bounce_gen

Interface
REQ-001 Parameter c_BOUNCE_COUNT, default 8: number of bounce pulses emitted before settling; range 1..255.
REQ-002 Parameter c_MIN_INTERVAL, default 500: minimum clocks between bounce edges; range 1..2^19.
REQ-003 Parameter c_SPAN_BITS, default 12: width of random extension added to each interval; range 0..16.
REQ-004 Parameter c_SETTLE_CYCLES, default 300_000: clocks the final level is held before completion; range 1..2^20-1.
REQ-005 Parameter c_LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-006 i_Clk  input  1  sole clock; all state updates on rising edge.
REQ-007 i_Rst  input  1  asynchronous, active-high reset.
REQ-008 i_Start  input  1  single-cycle request to begin a transition.
REQ-009 i_Level  input  1  target switch level, sampled only in the cycle i_Start is accepted.
REQ-010 o_Switch  output  1  emulated bouncing mechanical switch level, registered.
REQ-011 o_Busy  output  1  high from the cycle after start acceptance until o_Done.
REQ-012 o_Done  output  1  one-cycle pulse when the settle period expires.

Function
REQ-013 FSM states SHALL be IDLE, BOUNCE, SETTLE; reset state IDLE.
REQ-014 In IDLE, i_Start SHALL be accepted: target latched from i_Level; next state BOUNCE if i_Level != o_Switch, else SETTLE.
REQ-015 i_Start SHALL be ignored in BOUNCE and SETTLE; no effect on any state.
REQ-016 On entry to BOUNCE, o_Switch SHALL toggle in the same clock edge as the state change (first edge toward target).
REQ-017 In BOUNCE, o_Switch SHALL toggle once each time an interval counter expires, for 2*c_BOUNCE_COUNT-1 toggles total including the first, so the final level equals target.
REQ-018 Each interval SHALL equal c_MIN_INTERVAL + (LFSR value AND (2^c_SPAN_BITS - 1)) clocks, loaded at every toggle; c_SPAN_BITS=0 yields fixed intervals.
REQ-019 After the last toggle, FSM SHALL enter SETTLE with the settle counter loaded to c_SETTLE_CYCLES; o_Switch constant throughout SETTLE.
REQ-020 When the settle counter expires, o_Done SHALL pulse for exactly one cycle, o_Busy SHALL fall in that same cycle, FSM returns to IDLE.
REQ-021 i_Start in the same cycle o_Done pulses SHALL be ignored; next accepted start is the following cycle.
REQ-022 LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), advancing every clock regardless of state.
REQ-023 Interval and settle counters SHALL be 20 bits, unsigned, no wrap; parameter ranges guarantee no overflow.
REQ-024 Defaults SHALL place every bounce interval below and settle time above the 250_000-cycle debounce limit used by the board's switch debouncer.

Reset
REQ-025 i_Rst asserted SHALL immediately force: state IDLE, o_Switch 0, o_Busy 0, o_Done 0, counters 0, target 0, LFSR c_LFSR_SEED.
REQ-026 Reset mid-BOUNCE or mid-SETTLE SHALL abort without o_Done; operation resumes only on a new i_Start after release.
REQ-027 Reset deassertion SHALL be synchronized by the system; block assumes release is clean relative to i_Clk.

Structure
REQ-028 Package switch_pkg SHALL hold the state enum type, LFSR polynomial mask and default seed constants.
REQ-029 The LFSR SHALL be a sub-module lfsr16 (clock, reset, seed parameter, 16-bit state output); all else in one module.

Verification (c_BOUNCE_COUNT=3, c_MIN_INTERVAL=4, c_SPAN_BITS=2, c_SETTLE_CYCLES=10)
REQ-030 Reset, then i_Start with i_Level=1 -> o_Switch rises on acceptance edge, 5 toggles total each 4..7 clocks apart, ends at 1, o_Done one cycle exactly 10 clocks after last toggle.
REQ-031 From o_Switch=1, i_Start with i_Level=1 -> zero toggles, o_Busy high 10 cycles, single o_Done pulse.
REQ-032 i_Start repeated every cycle during BOUNCE with i_Level toggling -> toggle count and final level unchanged from first request.
REQ-033 i_Rst asserted between toggle 3 and 4 -> o_Switch, o_Busy 0 asynchronously, no o_Done, next start behaves as REQ-030 with identical interval sequence.
REQ-034 c_SPAN_BITS=0 -> every interval exactly 4 clocks.
REQ-035 Chain output into debouncer with default parameters -> debounced output changes once per transition, never during bounce.
